// File: rtl/nco_iq_mixer_pkg.sv
// Default widths and fixed-point constants shared by the NCO I/Q mixer and its
// multiply/round/saturate slice.
package nco_iq_pkg;

    localparam int DW_DEF       = 16;
    localparam int NW_DEF       = 16;
    localparam int OW_DEF       = 16;
    localparam int FFT_LOG2_DEF = 10;

    // Half an output LSB once the product is scaled down by 2^(NW-1).
    localparam int ROUND_CONST = 2 ** (NW_DEF - 2);

    localparam logic signed [OW_DEF-1:0] SAT_MAX = {1'b0, {(OW_DEF-1){1'b1}}};
    localparam logic signed [OW_DEF-1:0] SAT_MIN = {1'b1, {(OW_DEF-1){1'b0}}};

    localparam int FRAME_LEN = 2 ** FFT_LOG2_DEF;

endpackage

// File: rtl/nco_iq_mixer_round_sat.sv
// One mixer lane: registered signed multiply (S2), then optional negate,
// round-half-up, saturate and register the result (S3).
module mixer_round_sat
    import nco_iq_pkg::*;
#(
    parameter int                   DW     = DW_DEF,
    parameter int                   NW     = NW_DEF,
    parameter int                   OW     = OW_DEF,
    parameter int                   RND_C  = ROUND_CONST,
    parameter logic signed [OW-1:0] SAT_HI = SAT_MAX,
    parameter logic signed [OW-1:0] SAT_LO = SAT_MIN,
    parameter bit                   NEGATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mul_en_i,
    input  logic                 res_en_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [NW-1:0] b_i,
    output logic signed [OW-1:0] res_o,
    output logic                 ovf_o
);

    localparam int PW = DW + NW;

    localparam logic signed [PW:0] HI_X = (PW+1)'(SAT_HI);
    localparam logic signed [PW:0] LO_X = (PW+1)'(SAT_LO);

    logic signed [PW-1:0] prod_q;
    logic signed [PW:0]   full_d;
    logic signed [PW:0]   rnd_d;
    logic signed [PW:0]   shf_d;
    logic                 ovf_hi_d;
    logic                 ovf_lo_d;
    logic signed [OW-1:0] res_d;
    logic signed [OW-1:0] res_q;

    // The extra top bit lets the negate and the rounding add never wrap.
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
        full_d = {prod_q[PW-1], prod_q};
        if (NEGATE) begin
            full_d = -full_d;
        end
        rnd_d    = full_d + (PW+1)'(RND_C);
        shf_d    = rnd_d >>> (NW - 1);
        ovf_hi_d = (shf_d > HI_X);
        ovf_lo_d = (shf_d < LO_X);
        res_d    = shf_d[OW-1:0];
        if (ovf_hi_d) begin
            res_d = SAT_HI;
        end else if (ovf_lo_d) begin
            res_d = SAT_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: datapath registers are reset too, because reset must drive i_out/q_out to 0.
            prod_q <= '0;
            res_q  <= '0;
        end else begin
            if (mul_en_i) begin
                prod_q <= PW'(a_i) * PW'(b_i);
            end
            if (res_en_i) begin
                res_q <= res_d;
            end
        end
    end

    assign res_o = res_q;
    assign ovf_o = ovf_hi_d | ovf_lo_d;

endmodule

// File: rtl/nco_iq_mixer.sv
// ADC x NCO complex down-converter: input register stage, two mixer lanes,
// valid pipe, FFT frame sop/eop tagging and a sticky saturation flag.
module nco_iq_mixer
    import nco_iq_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int NW       = NW_DEF,
    parameter int OW       = OW_DEF,
    parameter int FFT_LOG2 = $clog2(FRAME_LEN)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clken,
    input  logic signed [DW-1:0] adc_data,
    input  logic                 adc_valid,
    input  logic signed [NW-1:0] nco_cos,
    input  logic signed [NW-1:0] nco_sin,
    input  logic                 nco_valid,
    input  logic                 frame_sync,
    input  logic                 sat_clr,
    output logic signed [OW-1:0] i_out,
    output logic signed [OW-1:0] q_out,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 sat_flag
);

    localparam logic signed [OW-1:0]   SAT_HI   = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0]   SAT_LO   = {1'b1, {(OW-1){1'b0}}};
    localparam logic [FFT_LOG2-1:0]    CNT_LAST = '1;

    logic signed [DW-1:0]   adc_q;
    logic signed [NW-1:0]   cos_q;
    logic signed [NW-1:0]   sin_q;
    logic                   v1_q;
    logic                   v2_q;
    logic                   vout_q;
    logic                   sop_q;
    logic                   eop_q;
    logic                   sat_q;
    logic                   sat_d;
    logic [FFT_LOG2-1:0]    cnt_q;
    logic [FFT_LOG2-1:0]    cnt_d;
    logic                   ovf_i;
    logic                   ovf_q;
    logic                   res_en;

    assign res_en = clken & v2_q;

    mixer_round_sat #(
        .DW(DW), .NW(NW), .OW(OW), .RND_C(2 ** (NW - 2)),
        .SAT_HI(SAT_HI), .SAT_LO(SAT_LO), .NEGATE(1'b0)
    ) u_mix_i (
        .clk     (clk),
        .reset_n (reset_n),
        .mul_en_i(clken),
        .res_en_i(res_en),
        .a_i     (adc_q),
        .b_i     (cos_q),
        .res_o   (i_out),
        .ovf_o   (ovf_i)
    );

    mixer_round_sat #(
        .DW(DW), .NW(NW), .OW(OW), .RND_C(2 ** (NW - 2)),
        .SAT_HI(SAT_HI), .SAT_LO(SAT_LO), .NEGATE(1'b1)
    ) u_mix_q (
        .clk     (clk),
        .reset_n (reset_n),
        .mul_en_i(clken),
        .res_en_i(res_en),
        .a_i     (adc_q),
        .b_i     (sin_q),
        .res_o   (q_out),
        .ovf_o   (ovf_q)
    );

    // A sync pulse restarts numbering after the sample leaving S3 on the same edge.
    always_comb begin
        cnt_d = cnt_q;
        if (frame_sync) begin
            cnt_d = '0;
        end else if (v2_q) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = sat_q;
        if (v2_q && (ovf_i || ovf_q)) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            adc_q  <= '0;
            cos_q  <= '0;
            sin_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            vout_q <= 1'b0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            sat_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (clken) begin
            // NOTE: non-blocking assignments make each stage load its upstream value from before the edge.
            adc_q  <= adc_data;
            cos_q  <= nco_cos;
            sin_q  <= nco_sin;
            v1_q   <= adc_valid & nco_valid;
            v2_q   <= v1_q;
            vout_q <= v2_q;
            sop_q  <= v2_q && (cnt_q == '0);
            eop_q  <= v2_q && (cnt_q == CNT_LAST);
            sat_q  <= sat_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = vout_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_nco_iq_mixer.sv
// Randomised self-checking bench for nco_iq_mixer against a delay-queue
// reference model built from plain integer arithmetic.
module tb_nco_iq_mixer;

    localparam int     DW   = 16;
    localparam int     NW   = 16;
    localparam int     OW   = 16;
    localparam int     FL2  = 3;
    localparam int     FLEN = 1 << FL2;
    localparam longint HI   = (64'sd1 <<< (OW - 1)) - 1;
    localparam longint LO   = -(64'sd1 <<< (OW - 1));

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 clken;
    logic signed [DW-1:0] adc_data;
    logic                 adc_valid;
    logic signed [NW-1:0] nco_cos;
    logic signed [NW-1:0] nco_sin;
    logic                 nco_valid;
    logic                 frame_sync;
    logic                 sat_clr;
    logic signed [OW-1:0] i_out;
    logic signed [OW-1:0] q_out;
    logic                 out_valid;
    logic                 out_sop;
    logic                 out_eop;
    logic                 sat_flag;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nco_iq_mixer #(.DW(DW), .NW(NW), .OW(OW), .FFT_LOG2(FL2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .nco_cos   (nco_cos),
        .nco_sin   (nco_sin),
        .nco_valid (nco_valid),
        .frame_sync(frame_sync),
        .sat_clr   (sat_clr),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .sat_flag  (sat_flag)
    );

    // Reference model: each accepted sample waits two further enabled edges.
    typedef struct {
        int i;
        int q;
        bit ovf;
        int left;
    } smp_t;

    smp_t                 pend[$];
    logic                 e_valid, e_sop, e_eop, e_sat;
    logic signed [OW-1:0] e_i, e_q;
    int                   fcount;

    function automatic int rsat(input longint p, output bit ov);
        longint r;
        r  = (p + (64'sd1 <<< (NW - 2))) >>> (NW - 1);
        ov = 1'b0;
        if (r > HI) begin
            r  = HI;
            ov = 1'b1;
        end else if (r < LO) begin
            r  = LO;
            ov = 1'b1;
        end
        return int'(r);
    endfunction

    function void model_edge();
        smp_t s, n;
        bit   emit, oi, oq;
        if (!reset_n) begin
            pend.delete();
            {e_valid, e_sop, e_eop, e_sat} = 4'b0;
            e_i    = '0;
            e_q    = '0;
            fcount = 0;
            return;
        end
        if (!clken) return;
        emit = 1'b0;
        foreach (pend[k]) pend[k].left--;
        if (pend.size() > 0 && pend[0].left == 0) begin
            s    = pend.pop_front();
            emit = 1'b1;
        end
        if (adc_valid && nco_valid) begin
            n.i    = rsat(longint'(adc_data) * longint'(nco_cos), oi);
            n.q    = rsat(-(longint'(adc_data) * longint'(nco_sin)), oq);
            n.ovf  = oi | oq;
            n.left = 2;
            pend.push_back(n);
        end
        e_valid = emit;
        e_sop   = emit && (fcount == 0);
        e_eop   = emit && (fcount == FLEN - 1);
        if (emit) begin
            e_i    = OW'(s.i);
            e_q    = OW'(s.q);
            fcount = (fcount + 1) % FLEN;
        end
        if (emit && s.ovf) e_sat = 1'b1;
        else if (sat_clr)  e_sat = 1'b0;
        if (frame_sync) fcount = 0;
    endfunction

    function automatic string act_s();
        return $sformatf("v%0b sop%0b eop%0b sat%0b i=%0d q=%0d",
                         out_valid, out_sop, out_eop, sat_flag, i_out, q_out);
    endfunction

    function automatic string exp_s();
        return $sformatf("v%0b sop%0b eop%0b sat%0b i=%0d q=%0d",
                         e_valid, e_sop, e_eop, e_sat, e_i, e_q);
    endfunction

    function automatic int rnd16();
        if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic cyc(input bit ce, input bit av, input bit nv, input int a, input int c,
                       input int s, input bit fs, input bit clr, input bit rst);
        clken      = ce;
        adc_valid  = av;
        nco_valid  = nv;
        adc_data   = DW'(a);
        nco_cos    = NW'(c);
        nco_sin    = NW'(s);
        frame_sync = fs;
        sat_clr    = clr;
        reset_n    = !rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1, 1, 1, 1234, 5000, -7000, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        n_total++;
        if ({out_valid, out_sop, out_eop, sat_flag} !== 4'b0)
            $display("FAIL reset_flags: got %s, want all zero", act_s());
        else n_pass++;
        n_total++;
        if (i_out !== 16'sd0 || q_out !== 16'sd0)
            $display("FAIL reset_data: got i=%0d q=%0d, want 0 0", i_out, q_out);
        else n_pass++;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_basic_mix();
        cyc(1, 1, 1, 16384, 32767, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
            n_total++;
            if ({out_valid, out_sop, out_eop, sat_flag, i_out, q_out} !==
                {e_valid, e_sop, e_eop, e_sat, e_i, e_q})
                $display("FAIL basic_mix cyc%0d: got %s, want %s", k, act_s(), exp_s());
            else n_pass++;
            if (k == 1) begin
                n_total++;
                if (!(out_valid === 1'b1 && i_out === 16'sd16384 && q_out === 16'sd0 && sat_flag === 1'b0))
                    $display("FAIL basic_value: got %s, want v1 i=16384 q=0 sat0", act_s());
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        cyc(1, 1, 1, -32768, -32768, 0, 0, 0, 0);
        cyc(1, 1, 1, 32767, 0, 32767, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
            n_total++;
            if ({out_valid, out_sop, out_eop, sat_flag, i_out, q_out} !==
                {e_valid, e_sop, e_eop, e_sat, e_i, e_q})
                $display("FAIL saturation cyc%0d: got %s, want %s", k, act_s(), exp_s());
            else n_pass++;
        end
        n_total++;
        if (sat_flag !== 1'b1) $display("FAIL sat_sticky: got %b, want 1", sat_flag);
        else n_pass++;
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        n_total++;
        if (sat_flag !== 1'b0) $display("FAIL sat_clear: got %b, want 0", sat_flag);
        else n_pass++;
        // A clamp leaving S3 on the same edge as sat_clr keeps the flag set.
        cyc(1, 1, 1, -32768, -32768, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        n_total++;
        if (sat_flag !== 1'b1 || sat_flag !== e_sat)
            $display("FAIL sat_set_wins: got %b, want 1", sat_flag);
        else n_pass++;
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_framing();
        int n_out = 0, n_sop = 0, n_eop = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 26; k++) begin
            cyc(1, k < 22, !(k == 11 || k == 12), rnd16(), rnd16(), rnd16(), 0, 0, 0);
            n_total++;
            if ({out_valid, out_sop, out_eop, sat_flag, i_out, q_out} !==
                {e_valid, e_sop, e_eop, e_sat, e_i, e_q})
                $display("FAIL framing cyc%0d: got %s, want %s", k, act_s(), exp_s());
            else n_pass++;
            if (out_valid) n_out++;
            if (out_sop)   n_sop++;
            if (out_eop)   n_eop++;
        end
        n_total++;
        if (n_out != 20 || n_sop != 3 || n_eop != 2)
            $display("FAIL framing_counts: got out=%0d sop=%0d eop=%0d, want 20 3 2", n_out, n_sop, n_eop);
        else n_pass++;
    endtask

    task automatic test_clken();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, rnd16(), rnd16(), rnd16(), 0, 0, 0);
        cyc(1, 1, 1, rnd16(), rnd16(), rnd16(), 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if (k < 5) cyc(0, 1, 1, rnd16(), rnd16(), rnd16(), 1, 1, 0);
            else       cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
            n_total++;
            if ({out_valid, out_sop, out_eop, sat_flag, i_out, q_out} !==
                {e_valid, e_sop, e_eop, e_sat, e_i, e_q})
                $display("FAIL clken cyc%0d: got %s, want %s", k, act_s(), exp_s());
            else n_pass++;
            n_total++;
            if (out_valid !== 1'b1 || out_sop !== (k < 5))
                $display("FAIL clken_hold cyc%0d: got v%b sop%b, want v1 sop%0b", k, out_valid, out_sop, k < 5);
            else n_pass++;
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_frame_sync();
        int n_eop = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 18; k++) begin
            cyc(1, k < 16, 1, rnd16(), rnd16(), rnd16(), k == 8, 0, 0);
            n_total++;
            if ({out_valid, out_sop, out_eop, sat_flag, i_out, q_out} !==
                {e_valid, e_sop, e_eop, e_sat, e_i, e_q})
                $display("FAIL frame_sync cyc%0d: got %s, want %s", k, act_s(), exp_s());
            else n_pass++;
            if (out_eop) n_eop++;
            if (k == 9) begin
                n_total++;
                if (out_valid !== 1'b1 || out_sop !== 1'b1)
                    $display("FAIL sync_sop: got v%b sop%b, want v1 sop1", out_valid, out_sop);
                else n_pass++;
            end
        end
        n_total++;
        if (n_eop != 1) $display("FAIL sync_eop_count: got %0d, want 1", n_eop);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) cyc(1, 1, 1, rnd16(), rnd16(), rnd16(), 0, 0, 0);
        cyc(1, 1, 1, rnd16(), rnd16(), rnd16(), 0, 0, 1);
        n_total++;
        if ({out_valid, out_sop, out_eop, sat_flag, i_out, q_out} !== '0)
            $display("FAIL reset_mid_zero: got %s, want all zero", act_s());
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            cyc(1, k == 1, 1, rnd16(), rnd16(), rnd16(), 0, 0, 0);
            n_total++;
            if ({out_valid, out_sop, out_eop, sat_flag, i_out, q_out} !==
                {e_valid, e_sop, e_eop, e_sat, e_i, e_q})
                $display("FAIL reset_mid cyc%0d: got %s, want %s", k, act_s(), exp_s());
            else n_pass++;
            n_total++;
            if (out_valid !== (k == 3) || out_sop !== (k == 3))
                $display("FAIL reset_mid_sop cyc%0d: got v%b sop%b, want v%0b sop%0b",
                         k, out_valid, out_sop, k == 3, k == 3);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                rnd16(), rnd16(), rnd16(), $urandom_range(0, 29) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
            n_total++;
            if ({out_valid, out_sop, out_eop, sat_flag, i_out, q_out} !==
                {e_valid, e_sop, e_eop, e_sat, e_i, e_q})
                $display("FAIL random cyc%0d: got %s, want %s", k, act_s(), exp_s());
            else n_pass++;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        clken      = 1'b1;
        adc_valid  = 1'b0;
        nco_valid  = 1'b0;
        adc_data   = '0;
        nco_cos    = '0;
        nco_sin    = '0;
        frame_sync = 1'b0;
        sat_clr    = 1'b0;
        fcount     = 0;
        {e_valid, e_sop, e_eop, e_sat} = 4'b0;
        e_i = '0;
        e_q = '0;
        @(negedge clk);
        test_reset();
        test_basic_mix();
        test_saturation();
        test_framing();
        test_clken();
        test_frame_sync();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
